id_stage: RTL and testbench



---
 rtl/mips_pkg.sv | 65 ++++++
 rtl/reg_file.sv | 39 +++
 rtl/id_stage.sv | 101 ++++++++++
 tb/tb_id_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcodes, ALUOp encodings and ID/EX control-bundle layout shared by the decode stage
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam int REG_AW = 5;

  localparam int WB_W = 2;
  localparam int M_W  = 3;
  localparam int EX_W = 4;

  localparam int WB_REGWRITE  = 1;
  localparam int WB_MEMTOREG  = 0;
  localparam int M_BRANCH     = 2;
  localparam int M_MEMREAD    = 1;
  localparam int M_MEMWRITE   = 0;
  localparam int EX_REGDST    = 3;
  localparam int EX_ALUOP_LSB = 1;
  localparam int EX_ALUSRC    = 0;

  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
    logic [EX_W-1:0] ex;
  } ctl_t;

  // Unknown opcodes decode to all-zero control, i.e. a bubble.
  function automatic ctl_t decode_ctl(input logic [5:0] opcode);
    ctl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        c.ex[EX_REGDST]            = 1'b1;
        c.ex[EX_ALUOP_LSB +: 2]    = ALUOP_FUNCT;
        c.wb[WB_REGWRITE]          = 1'b1;
      end
      OP_LW: begin
        c.ex[EX_ALUSRC]            = 1'b1;
        c.ex[EX_ALUOP_LSB +: 2]    = ALUOP_ADD;
        c.m[M_MEMREAD]             = 1'b1;
        c.wb[WB_REGWRITE]          = 1'b1;
        c.wb[WB_MEMTOREG]          = 1'b1;
      end
      OP_SW: begin
        c.ex[EX_ALUSRC]            = 1'b1;
        c.ex[EX_ALUOP_LSB +: 2]    = ALUOP_ADD;
        c.m[M_MEMWRITE]            = 1'b1;
      end
      OP_BEQ: begin
        c.ex[EX_ALUOP_LSB +: 2]    = ALUOP_SUB;
        c.m[M_BRANCH]              = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 2R1W register file, R0 hardwired to zero; ID_WB_BYPASS_EN enables write-through reads
module reg_file
  import mips_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] mem [REG_CNT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_CNT; i++) mem[i] <= '0;
    end else if (we && wa != '0) begin
      mem[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = (ra1 == '0) ? '0 : mem[ra1];
    rd2 = (ra2 == '0) ? '0 : mem[ra2];
`ifdef ID_WB_BYPASS_EN
    // wa != 0 already keeps R0 reading zero under bypass.
    if (we && wa != '0 && wa == ra1) rd1 = wd;
    if (we && wa != '0 && wa == ra2) rd2 = wd;
`endif
  end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - MIPS decode stage: IF/ID latch, decode, register read, ID/EX latch (ID_WB_BYPASS_EN selects register-file bypass)
module id_stage
  import mips_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] npc_in,
  input  logic [31:0]       instr_in,
  input  logic              stall,
  input  logic              flush,
  input  logic              wb_regwrite,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] npc_out,
  output logic [DATA_W-1:0] rd1_out,
  output logic [DATA_W-1:0] rd2_out,
  output logic [DATA_W-1:0] sext_out,
  output logic [4:0]        rt_out,
  output logic [4:0]        rd_out,
  output logic [1:0]        wb_ctl,
  output logic [2:0]        m_ctl,
  output logic [3:0]        ex_ctl
);

  logic [DATA_W-1:0] ifid_npc;
  logic [31:0]       ifid_instr;

  // Flush has priority so a taken branch clears IF/ID even while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_npc   <= '0;
      ifid_instr <= '0;
    end else if (flush) begin
      ifid_npc   <= '0;
      ifid_instr <= '0;
    end else if (!stall) begin
      ifid_npc   <= npc_in;
      ifid_instr <= instr_in;
    end
  end

  logic [5:0]        opcode;
  logic [4:0]        rs, rt, rd;
  logic [15:0]       imm;
  logic [DATA_W-1:0] rs_data, rt_data, sext;
  ctl_t              ctl;
  logic              bubble;

  assign opcode = ifid_instr[31:26];
  assign rs     = ifid_instr[25:21];
  assign rt     = ifid_instr[20:16];
  assign rd     = ifid_instr[15:11];
  assign imm    = ifid_instr[15:0];
  assign sext   = {{(DATA_W-16){imm[15]}}, imm};
  assign ctl    = decode_ctl(opcode);
  assign bubble = stall | flush;

  reg_file #(
    .DATA_W (DATA_W),
    .REG_CNT(REG_CNT)
  ) u_reg_file (
    .clk  (clk),
    .rst_n(rst_n),
    .ra1  (rs),
    .ra2  (rt),
    .rd1  (rs_data),
    .rd2  (rt_data),
    .we   (wb_regwrite),
    .wa   (wb_rd),
    .wd   (wb_data)
  );

  // Data fields always load; only the control bits are zeroed for a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      npc_out  <= '0;
      rd1_out  <= '0;
      rd2_out  <= '0;
      sext_out <= '0;
      rt_out   <= '0;
      rd_out   <= '0;
      wb_ctl   <= '0;
      m_ctl    <= '0;
      ex_ctl   <= '0;
    end else begin
      npc_out  <= ifid_npc;
      rd1_out  <= rs_data;
      rd2_out  <= rt_data;
      sext_out <= sext;
      rt_out   <= rt;
      rd_out   <= rd;
      wb_ctl   <= bubble ? '0 : ctl.wb;
      m_ctl    <= bubble ? '0 : ctl.m;
      ex_ctl   <= bubble ? '0 : ctl.ex;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - scoreboard bench for id_stage; reference model follows ID_WB_BYPASS_EN
`timescale 1ns/1ps
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] npc_in = '0;
  logic [31:0] instr_in = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        wb_regwrite = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic [31:0] npc_out, rd1_out, rd2_out, sext_out;
  logic [4:0]  rt_out, rd_out;
  logic [1:0]  wb_ctl;
  logic [2:0]  m_ctl;
  logic [3:0]  ex_ctl;

  always #5 clk = ~clk;

  id_stage #(.DATA_W(32), .REG_CNT(32)) dut (
    .clk(clk), .rst_n(rst_n), .npc_in(npc_in), .instr_in(instr_in),
    .stall(stall), .flush(flush), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .wb_data(wb_data), .npc_out(npc_out), .rd1_out(rd1_out), .rd2_out(rd2_out),
    .sext_out(sext_out), .rt_out(rt_out), .rd_out(rd_out), .wb_ctl(wb_ctl),
    .m_ctl(m_ctl), .ex_ctl(ex_ctl)
  );

`ifdef ID_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] npc, rd1, rd2, sext;
    logic [4:0]  rt, rd;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
  } bundle_t;

  bundle_t     exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_regs [32];
  logic [31:0] m_npc = '0;
  logic [31:0] m_instr = '0;

  function automatic bundle_t actual();
    bundle_t a;
    a.npc = npc_out; a.rd1 = rd1_out; a.rd2 = rd2_out; a.sext = sext_out;
    a.rt = rt_out; a.rd = rd_out; a.wb = wb_ctl; a.m = m_ctl; a.ex = ex_ctl;
    return a;
  endfunction

  // {RegWrite,MemtoReg, Branch,MemRead,MemWrite, RegDst,ALUOp[1:0],ALUSrc}
  function automatic logic [8:0] ref_ctl(input logic [5:0] op);
    case (op)
      6'h00:   return 9'b10_000_1100;
      6'h23:   return 9'b11_010_0001;
      6'h2B:   return 9'b00_001_0001;
      6'h04:   return 9'b00_100_0010;
      default: return 9'b00_000_0000;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (BYPASS && we && wa == a) return wd;
    return m_regs[a];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One clock of stimulus: drive at negedge, push what the next posedge must produce.
  task automatic cycle(input logic r, input logic st, input logic fl, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd,
                       input logic [31:0] npc, input logic [31:0] ins);
    bundle_t e;
    @(negedge clk);
    rst_n = r; stall = st; flush = fl; wb_regwrite = we; wb_rd = wa; wb_data = wd;
    npc_in = npc; instr_in = ins;
    e = '0;
    if (!r) begin
      #1;
      check("async_reset_bundle_nonzero", 32'(actual() != '0), 32'd0);
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_npc = '0;
      m_instr = '0;
    end else begin
      e.npc  = m_npc;
      e.rd1  = ref_read(m_instr[25:21], we, wa, wd);
      e.rd2  = ref_read(m_instr[20:16], we, wa, wd);
      e.sext = 32'($signed(m_instr[15:0]));
      e.rt   = m_instr[20:16];
      e.rd   = m_instr[15:11];
      {e.wb, e.m, e.ex} = (st || fl) ? 9'd0 : ref_ctl(m_instr[31:26]);
      if (we && wa != 5'd0) m_regs[wa] = wd;
      if (fl) begin
        m_npc = '0;
        m_instr = '0;
      end else if (!st) begin
        m_npc = npc;
        m_instr = ins;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    case ($urandom_range(0, 4))
      0:       op = 6'h00;
      1:       op = 6'h23;
      2:       op = 6'h2B;
      3:       op = 6'h04;
      default: op = 6'($urandom_range(0, 63));
    endcase
    return {op, 26'($urandom)};
  endfunction

  initial begin : monitor
    bundle_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = actual();
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL bundle @%0t: got npc=%h rd1=%h rd2=%h sx=%h rt=%h rd=%h wb=%b m=%b ex=%b expected npc=%h rd1=%h rd2=%h sx=%h rt=%h rd=%h wb=%b m=%b ex=%b",
                   $time, a.npc, a.rd1, a.rd2, a.sext, a.rt, a.rd, a.wb, a.m, a.ex,
                   e.npc, e.rd1, e.rd2, e.sext, e.rt, e.rd, e.wb, e.m, e.ex);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    for (int i = 0; i < 32; i++) m_regs[i] = '0;

    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
    idle();
    idle();
    settle();
    check("idle_ex", 32'(ex_ctl), 32'h0000_000C);
    check("idle_wb", 32'(wb_ctl), 32'h0000_0002);
    check("idle_m", 32'(m_ctl), 32'd0);

    cycle(1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 32'd5, 32'd0, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 32'd7, 32'd0, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd4, 32'h0022_1820);
    idle();
    settle();
    check("add_rd1", rd1_out, 32'd5);
    check("add_rd2", rd2_out, 32'd7);
    check("add_rd", 32'(rd_out), 32'd3);
    check("add_npc", npc_out, 32'd4);
    check("add_ex", 32'(ex_ctl), 32'h0000_000C);
    check("add_m", 32'(m_ctl), 32'd0);

    cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd8, 32'h8C24_FFF8);
    idle();
    settle();
    check("lw_sext", sext_out, 32'hFFFF_FFF8);
    check("lw_ex", 32'(ex_ctl), 32'd1);
    check("lw_m", 32'(m_ctl), 32'd2);
    check("lw_wb", 32'(wb_ctl), 32'd3);
    check("lw_rt", 32'(rt_out), 32'd4);

    cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd12, 32'hAC22_0010);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd99, 32'h8C24_FFF8);
    settle();
    check("stall1_ctl", {23'd0, wb_ctl, m_ctl, ex_ctl}, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd99, 32'h8C24_FFF8);
    settle();
    check("stall2_ctl", {23'd0, wb_ctl, m_ctl, ex_ctl}, 32'd0);
    idle();
    settle();
    check("sw_m", 32'(m_ctl), 32'd1);
    check("sw_ex", 32'(ex_ctl), 32'd1);
    check("sw_npc", npc_out, 32'd12);

    cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd16, 32'h1022_0003);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 32'd20, 32'h8C24_FFF8);
    settle();
    check("flush_ctl", {23'd0, wb_ctl, m_ctl, ex_ctl}, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd24, 32'h8C24_FFF8);
    settle();
    check("after_flush_ex", 32'(ex_ctl), 32'h0000_000C);
    check("after_flush_m", 32'(m_ctl), 32'd0);
    check("after_flush_npc", npc_out, 32'd0);

    cycle(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'h11, 32'd0, 32'h00A0_3020);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'd0, 32'd0);
    settle();
    check("bypass_rd1", rd1_out, BYPASS ? 32'h1234 : 32'h11);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'hDEAD, 32'd0, 32'h0000_3020);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'hBEEF, 32'd0, 32'd0);
    settle();
    check("r0_rd1", rd1_out, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'h00A0_3020);
    idle();
    settle();
    check("r5_committed", rd1_out, 32'h1234);

    cycle(1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 32'h77, 32'd0, 32'h00E8_3020);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 32'h88, 32'd0, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 32'h99, 32'd0, 32'h00E8_3020);
    idle();
    settle();
    check("release_wb_rd1", rd1_out, 32'h99);
    check("reset_no_write_rd2", rd2_out, 32'd0);

    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 149) != 0),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 7) == 0),
            1'($urandom),
            5'($urandom),
            $urandom,
            $urandom & 32'hFFFF_FFFC,
            rand_instr());
    end
    idle();
    idle();
    settle();
    #2;
    check("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
